scope_trig_capture: RTL and testbench

Parametrised, triggered, multi-channel capture engine with ping-pong buffering. It sits between the ADC sample front end and the VGA trace renderer, replacing free-running 640-sample single-channel capture. Decimated sample sets are qualified by a level/edge trigger and written into a back bank. Banks swap only at a display vertical-sync boundary, so the renderer never reads a half-written frame.

---
 rtl/scope_pkg.sv | 31 +++
 rtl/scope_pingpong_ram.sv | 40 ++++
 rtl/scope_trig_capture.sv | 176 +++++++++++++++++
 tb/tb_scope_trig_capture.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// scope_pkg: shared states, modes and lane helper for the triggered scope
// capture engine.
package scope_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        DONE    = 3'd3
    } state_t;

    typedef enum logic [1:0] {
        STOP   = 2'd0,
        NORMAL = 2'd1,
        SINGLE = 2'd2
    } mode_t;

    localparam int LANE_MAX_W = 1024;

    // Lane ch of a packed multi-channel word, each lane w bits wide.
    function automatic logic [31:0] lane_slice(
        input logic [LANE_MAX_W-1:0] data,
        input int unsigned           ch,
        input int unsigned           w
    );
        logic [LANE_MAX_W-1:0] sh;
        sh = data >> (ch * w);
        return sh[31:0] & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/scope_pingpong_ram.sv
// scope_pingpong_ram: two frame banks; writes go to the back bank, the
// registered read port serves the front bank.
module scope_pingpong_ram
    import scope_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int DW    = 24,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          bank,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    logic          rd_ok;

    assign rd_ok = {1'b0, rd_addr} < (AW+1)'(DEPTH);

    always_ff @(posedge clk) begin
        if (we) begin
            if (bank) mem0[wr_addr] <= wr_data;
            else      mem1[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       rd_data <= '0;
        else if (!rd_ok) rd_data <= '0;
        else if (bank)   rd_data <= mem1[rd_addr];
        else             rd_data <= mem0[rd_addr];
    end

endmodule

// File: rtl/scope_trig_capture.sv
// scope_trig_capture: decimated, level/edge-triggered capture into ping-pong
// banks swapped on vsync. Forced trigger optional via SCOPE_AUTO_TRIG_EN.
module scope_trig_capture
    import scope_pkg::*;
#(
    parameter int SAMPLE_W     = 12,
    parameter int NCH          = 2,
    parameter int DEPTH        = 640,
    parameter int DECIM_W      = 8,
    parameter int AUTO_TIMEOUT = 4096,
    localparam int DW  = NCH * SAMPLE_W,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    input  logic [DW-1:0]       s_data,
    input  logic [1:0]          cfg_mode,
    input  logic [CHW-1:0]      cfg_trig_ch,
    input  logic [SAMPLE_W-1:0] cfg_trig_level,
    input  logic                cfg_trig_rising,
    input  logic [DECIM_W-1:0]  cfg_decim,
    input  logic                arm,
    input  logic                vsync_pulse,
    input  logic [AW-1:0]       rd_addr,
    output logic [DW-1:0]       rd_data,
    output logic [2:0]          state_o,
    output logic                frame_swap,
    output logic                auto_fired
);

    state_t              state, state_nxt;
    mode_t               l_mode;
    logic                bank, bank_nxt;
    logic [DECIM_W-1:0]  dcnt, l_decim;
    logic [CHW-1:0]      l_ch;
    logic [SAMPLE_W-1:0] l_level, prev, cur;
    logic                l_rising, prev_vld;
    logic [AW-1:0]       waddr, wr_addr;
    logic                active, kept, hit, auto_hit, fire;
    logic                wr_last, we, enter_arm, swap;

    assign cur = SAMPLE_W'(lane_slice(LANE_MAX_W'(s_data),
                                      32'(l_ch), 32'(SAMPLE_W)));

    assign active  = (state == ARMED) || (state == CAPTURE);
    assign kept    = active && s_valid && (dcnt == '0);
    assign hit     = prev_vld && (l_rising ?
                     (prev <  l_level && cur >= l_level) :
                     (prev >= l_level && cur <  l_level));
    assign fire    = kept && (state == ARMED) && (hit || auto_hit);
    assign wr_addr = (state == ARMED) ? '0 : waddr;
    assign wr_last = wr_addr == AW'(DEPTH - 1);
    assign bank_nxt = bank ^ swap;
    assign state_o = state;

    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        enter_arm = 1'b0;
        swap      = 1'b0;
        if (cfg_mode == STOP) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (arm) begin
                    state_nxt = ARMED;
                    enter_arm = 1'b1;
                end
                ARMED: if (fire) begin
                    we        = 1'b1;
                    state_nxt = wr_last ? DONE : CAPTURE;
                end
                CAPTURE: if (kept) begin
                    we = 1'b1;
                    if (wr_last) state_nxt = DONE;
                end
                DONE: if (vsync_pulse) begin
                    swap = 1'b1;
                    if (l_mode == NORMAL) begin
                        state_nxt = ARMED;
                        enter_arm = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bank       <= 1'b0;
            frame_swap <= 1'b0;
            dcnt       <= '0;
            waddr      <= '0;
            prev       <= '0;
            prev_vld   <= 1'b0;
            l_mode     <= STOP;
            l_decim    <= '0;
            l_ch       <= '0;
            l_level    <= '0;
            l_rising   <= 1'b0;
        end else begin
            state      <= state_nxt;
            bank       <= bank_nxt;
            frame_swap <= swap;
            if (enter_arm) begin
                l_mode   <= mode_t'(cfg_mode);
                l_decim  <= cfg_decim;
                l_ch     <= cfg_trig_ch;
                l_level  <= cfg_trig_level;
                l_rising <= cfg_trig_rising;
                dcnt     <= '0;
                waddr    <= '0;
                prev_vld <= 1'b0;
            end else begin
                if (active && s_valid)
                    dcnt <= (dcnt == l_decim) ? '0 : dcnt + 1'b1;
                if (kept && state == ARMED) begin
                    prev     <= cur;
                    prev_vld <= 1'b1;
                end
                if (we)
                    waddr <= wr_last ? '0 : wr_addr + 1'b1;
            end
        end
    end

`ifdef SCOPE_AUTO_TRIG_EN
    localparam int ACW = $clog2(AUTO_TIMEOUT + 1);
    logic [ACW-1:0] acnt;
    logic           auto_q;

    // The set that completes the timeout count is itself the trigger.
    assign auto_hit   = acnt == ACW'(AUTO_TIMEOUT - 1);
    assign auto_fired = auto_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acnt   <= '0;
            auto_q <= 1'b0;
        end else begin
            if (enter_arm)
                acnt <= '0;
            else if (kept && state == ARMED)
                acnt <= acnt + 1'b1;
            if (fire)
                auto_q <= !hit;
        end
    end
`else
    // Timeout parameter is inert in this build.
    assign auto_hit   = 1'b0 & (AUTO_TIMEOUT < 1);
    assign auto_fired = 1'b0;
`endif

    scope_pingpong_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .bank    (bank_nxt),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (s_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_scope_trig_capture.sv
// tb_scope_trig_capture: randomized stimulus against a list-based model of
// decimation, triggering and frame contents.
module tb_scope_trig_capture;

    localparam int SW    = 12;
    localparam int NCH   = 2;
    localparam int DEPTH = 640;
    localparam int TO    = 16;
`ifdef SCOPE_AUTO_TRIG_EN
    localparam bit AUTO_ON = 1'b1;
`else
    localparam bit AUTO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic [23:0] s_data = '0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [0:0]  cfg_trig_ch = 1'b0;
    logic [11:0] cfg_trig_level = '0;
    logic        cfg_trig_rising = 1'b1;
    logic [7:0]  cfg_decim = '0;
    logic        arm = 1'b0;
    logic        vsync_pulse = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [23:0] rd_data;
    logic [2:0]  state_o;
    logic        frame_swap;
    logic        auto_fired;

    always #5 clk = ~clk;

    scope_trig_capture #(
        .SAMPLE_W     (SW),
        .NCH          (NCH),
        .DEPTH        (DEPTH),
        .DECIM_W      (8),
        .AUTO_TIMEOUT (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .s_valid         (s_valid),
        .s_data          (s_data),
        .cfg_mode        (cfg_mode),
        .cfg_trig_ch     (cfg_trig_ch),
        .cfg_trig_level  (cfg_trig_level),
        .cfg_trig_rising (cfg_trig_rising),
        .cfg_decim       (cfg_decim),
        .arm             (arm),
        .vsync_pulse     (vsync_pulse),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .state_o         (state_o),
        .frame_swap      (frame_swap),
        .auto_fired      (auto_fired)
    );

    int total = 0;
    int bad = 0;

    logic [23:0] kq[$];
    logic [23:0] exp_f [DEPTH];
    logic [23:0] exp_b [DEPTH];
    int  vcnt, trig_idx, m_decim, m_ch, m_lvl;
    bit  m_rise, logging, mdone, exp_auto;
    logic [11:0] ramp;
    int  tagc;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int lane(input logic [23:0] d, input int ch);
        logic [23:0] t;
        t = (d >> (ch * SW)) & 24'hFFF;
        return int'(t);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_arm;
        kq.delete();
        vcnt     = 0;
        trig_idx = -1;
        logging  = 1'b1;
        mdone    = 1'b0;
        m_decim  = int'(cfg_decim);
        m_ch     = int'(cfg_trig_ch);
        m_lvl    = int'(cfg_trig_level);
        m_rise   = cfg_trig_rising;
    endtask

    task automatic model_push(input logic [23:0] d);
        int n, a, b;
        if (vcnt % (m_decim + 1) == 0) begin
            kq.push_back(d);
            n = kq.size();
            if (trig_idx < 0 && n >= 2) begin
                a = lane(kq[n-2], m_ch);
                b = lane(kq[n-1], m_ch);
                if (m_rise ? (a < m_lvl && b >= m_lvl)
                           : (a >= m_lvl && b < m_lvl)) begin
                    trig_idx = n - 1;
                    exp_auto = 1'b0;
                end
            end
            if (AUTO_ON && trig_idx < 0 && n == TO) begin
                trig_idx = n - 1;
                exp_auto = 1'b1;
            end
            if (trig_idx >= 0 && n - trig_idx == DEPTH) begin
                mdone   = 1'b1;
                logging = 1'b0;
            end
        end
        vcnt++;
    endtask

    task automatic step(input bit v, input logic [23:0] d, input bit vs,
                        input bit ar, input bit late);
        s_valid     = v;
        s_data      = d;
        vsync_pulse = vs;
        arm         = ar;
        if (v && logging) begin
            model_push(d);
            if (late && mdone) vsync_pulse = 1'b1;
        end
        tick();
        s_valid     = 1'b0;
        vsync_pulse = 1'b0;
        arm         = 1'b0;
    endtask

    task automatic run_capture(input int kind, input int target,
                               input bit late);
        bit v;
        logic [23:0] d;
        int c;
        c = 0;
        while (!(trig_idx >= 0 && kq.size() - trig_idx >= target)
               && c < 8000) begin
            case (kind)
                0: begin
                    v = 1'b1;
                    d = {12'($urandom), ramp};
                    ramp++;
                end
                1: begin
                    v = $urandom_range(3) != 0;
                    d = {12'($urandom), ramp};
                    if (v) ramp++;
                end
                2: begin
                    v = $urandom_range(3) != 0;
                    d = 24'($urandom);
                end
                default: begin
                    v = 1'b1;
                    tagc++;
                    d = {12'(tagc), 12'h100};
                end
            endcase
            step(v, d, 1'b0, 1'b0, late);
            c++;
        end
        check("cap_bound", 32'(c < 8000), 1);
    endtask

    task automatic snap;
        for (int k = 0; k < DEPTH; k++) exp_f[k] = kq[trig_idx + k];
    endtask

    task automatic verify_front(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 10'(a);
            tick();
            check(tag, 32'(rd_data), 32'(exp_f[a]));
        end
    endtask

    task automatic do_swap(input string tag, input bit normal);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check({tag, "_swap"}, 32'(frame_swap), 1);
        if (normal) model_arm();
        tick();
        check({tag, "_swap_end"}, 32'(frame_swap), 0);
        check({tag, "_after_state"}, 32'(state_o), normal ? 1 : 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] v0;
        logging  = 1'b0;
        exp_auto = 1'b0;
        trig_idx = -1;
        tagc     = 0;
        ramp     = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state_o), 0);
        check("rst_swap", 32'(frame_swap), 0);
        check("rst_rd", 32'(rd_data), 0);
        check("rst_auto", 32'(auto_fired), 0);
        reset = 1'b0;
        tick();
        check("idle_hold", 32'(state_o), 0);

        // Rising trigger on a ramp, single shot.
        cfg_mode = 2'd2; cfg_decim = 8'd0; cfg_trig_level = 12'h800;
        cfg_trig_rising = 1'b1; cfg_trig_ch = 1'b0; ramp = 12'h7F0;
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        model_arm();
        check("a_armed", 32'(state_o), 1);
        run_capture(0, DEPTH, 1'b0);
        check("a_done", 32'(state_o), 3);
        check("a_auto", 32'(auto_fired), 32'(exp_auto));
        snap();
        do_swap("a", 1'b0);
        verify_front("a_frame");
        rd_addr = 10'd0;   tick(); check("a_addr0", 32'(rd_data[11:0]), 12'h800);
        rd_addr = 10'd639; tick(); check("a_addr639", 32'(rd_data[11:0]), 12'hA7F);
        rd_addr = 10'd640; tick(); check("a_oob640", 32'(rd_data), 0);
        rd_addr = 10'h3FF; tick(); check("a_oob1023", 32'(rd_data), 0);
        ramp = 12'h7F0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, {12'h0, ramp}, 1'b0, 1'b0, 1'b0);
            ramp++;
            check("a_single_idle", 32'(state_o), 0);
            check("a_single_noswap", 32'(frame_swap), 0);
        end
        rd_addr = 10'd0; tick(); check("a_front_kept", 32'(rd_data), 32'(exp_f[0]));

        // Decimation by 4, NORMAL mode, vsync on the final write.
        cfg_mode = 2'd1; cfg_decim = 8'd3; cfg_trig_level = 12'h400;
        ramp = 12'h3E0;
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        model_arm();
        run_capture(1, DEPTH, 1'b1);
        check("b_late_noswap", 32'(frame_swap), 0);
        check("b_late_done", 32'(state_o), 3);
        tick(); tick();
        check("b_wait_noswap", 32'(frame_swap), 0);
        check("b_wait_done", 32'(state_o), 3);
        check("b_auto", 32'(auto_fired), 32'(exp_auto));
        snap();
        exp_b = exp_f;
        do_swap("b", 1'b1);
        tick();
        check("b_rearm_hold", 32'(state_o), 1);
        verify_front("b_frame");
        rd_addr = 10'd0; tick(); v0 = rd_data[11:0];
        rd_addr = 10'd1; tick();
        check("b_decim_step", 32'(rd_data[11:0] - v0), 4);

        // Reset in the middle of a capture.
        ramp = 12'h300;
        run_capture(1, 100, 1'b0);
        check("rst_mid_cap", 32'(state_o), 2);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_state", 32'(state_o), 0);
        check("rst_mid_swap", 32'(frame_swap), 0);
        check("rst_mid_rd", 32'(rd_data), 0);
        check("rst_mid_auto", 32'(auto_fired), 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        tick();
        logging  = 1'b0;
        exp_auto = 1'b0;
        exp_f    = exp_b;
        verify_front("rst_front");

        // Falling trigger on channel 1 with random data, then STOP abort.
        cfg_mode = 2'd1; cfg_decim = 8'($urandom_range(2));
        cfg_trig_level = 12'h800; cfg_trig_rising = 1'b0; cfg_trig_ch = 1'b1;
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        model_arm();
        run_capture(2, DEPTH, 1'b0);
        check("c_done", 32'(state_o), 3);
        check("c_auto", 32'(auto_fired), 32'(exp_auto));
        snap();
        do_swap("c", 1'b1);
        verify_front("c_frame");
        run_capture(2, 50, 1'b0);
        check("abort_mid", 32'(state_o), 2);
        logging  = 1'b0;
        cfg_mode = 2'd0;
        step(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0);
        check("abort_idle", 32'(state_o), 0);
        tick();
        check("abort_noswap", 32'(frame_swap), 0);
        verify_front("abort_front");

`ifdef SCOPE_AUTO_TRIG_EN
        // Flat input never crosses the level; timeout forces the trigger.
        cfg_mode = 2'd2; cfg_decim = 8'd0; cfg_trig_level = 12'h800;
        cfg_trig_rising = 1'b1; cfg_trig_ch = 1'b0; tagc = 0;
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        model_arm();
        run_capture(3, DEPTH, 1'b0);
        check("auto_done", 32'(state_o), 3);
        check("auto_set", 32'(auto_fired), 1);
        snap();
        do_swap("auto", 1'b0);
        verify_front("auto_frame");
        rd_addr = 10'd0; tick();
        check("auto_start", 32'(rd_data[23:12]), 16);
        cfg_mode = 2'd1; ramp = 12'h7F8;
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        model_arm();
        run_capture(0, DEPTH, 1'b0);
        check("auto_cleared", 32'(auto_fired), 0);
        snap();
        do_swap("gen", 1'b1);
        verify_front("gen_frame");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
